data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the load/store requests issued by the memory stage of the segmented RISC-V core. It accepts one request at a time over a valid/ready handshake. It performs byte, half or word accesses using the DMCtrl (funct3) encoding and returns load data after a fixed, parameterised latency. While a request is outstanding it drives a stall back to the pipeline's hazard logic.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, default 2: clock edges from acceptance to the response cycle; 1..15.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low bytes are used for SB/SH.
- `req_ctrl` in 3: DMCtrl. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Other codes are treated as 010.
- `req_ready` out 1: request can be accepted this cycle.
- `rsp_valid` out 1: one-cycle response strobe. Asserted for loads and stores.
- `rsp_rdata` out 32: load result, extended per `req_ctrl`. Zero for stores.
- `rsp_err` out 1: misaligned access flag, valid with `rsp_valid`. Only present with the macro enabled; tied 0 otherwise.
- `stall` out 1: hold the pipeline. Combinational.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid`, the request is accepted on the edge.
  - The address, ctrl and we are latched.
  - The down-counter is loaded with LATENCY-1.
  - The next state is RESP if LATENCY=1, otherwise BUSY.
- BUSY: the counter decrements each edge. Leave for RESP on the edge where the counter is 1.
- RESP: `rsp_valid`=1 for exactly this cycle. The state returns to IDLE on the next edge. No acceptance occurs in RESP, so requests are accepted at most once every LATENCY+1 cycles.
- Word index is `req_addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so the address wraps modulo DEPTH_WORDS*4.
- Stores are committed to the array on the acceptance edge.
  - Byte enables come from `req_ctrl[1:0]` and `req_addr[1:0]`.
  - SB writes byte addr[1:0].
  - SH writes halfword addr[1].
  - SW writes the full word.
- Loads read the array on the acceptance edge into a data register.
  - Byte/half selection uses the latched addr[1:0].
  - Sign extension applies when ctrl[2]=0; zero extension when ctrl[2]=1.
  - `rsp_rdata` holds this value only while `rsp_valid`=1 and is 0 otherwise.
- `stall` = (state != IDLE && state != RESP) || (state == IDLE && req_valid). It is therefore low in the RESP cycle, so the pipeline advances with the data.
- A request arriving while a store to the same word is in progress cannot occur, because only one request is outstanding.
- Array contents are not cleared by reset. Initial contents are undefined unless loaded by the bench.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `stall` follows `req_valid`.
- Latency: acceptance at edge E0 gives `rsp_valid` high in the cycle after edge E0+LATENCY-1.
- A reset assertion in BUSY or RESP forces IDLE immediately and drops `rsp_valid`.
  - A store already accepted stays committed.
  - A store whose acceptance edge coincides with `rst_n` low is not committed.
- `req_*` inputs are sampled only on the acceptance edge and may change freely afterwards.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses raise `rsp_err`=1 with `rsp_valid`. These are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - Misaligned stores are not committed.
  - Misaligned loads return `rsp_rdata`=0.
  - Latency is unchanged.
- Not defined:
  - The misaligned low address bits are forced to zero (halfword: addr[0]; word: addr[1:0]) and the access proceeds.
  - `rsp_err` is constant 0.

## Test plan
- Reset, LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10. Response arrives 2 edges after each acceptance with `rsp_rdata`=0xDEADBEEF; `stall` is high for 2 cycles per request.
- Byte/half: after SW 0x80FF7F01 at 0x20, the loads return:
  - LB 0x23 = 0xFFFFFF80
  - LBU 0x23 = 0x00000080
  - LH 0x22 = 0xFFFF80FF
  - LHU 0x20 = 0x00007F01
- Partial store: SB 0xAA to 0x21 over 0x11223344, then LW 0x20 = 0x1122AA44. SH 0xBEEF to 0x22 then gives 0xBEEFAA44.
- Wrap: with DEPTH_WORDS=256, SW 0x5 to 0x400, then LW 0x0 returns 0x5.
- Misaligned, with the macro defined: LW 0x21 gives `rsp_err`=1 and `rsp_rdata`=0. SW 0x22 is not committed. With the macro undefined, LW 0x21 returns word 0x20 and `rsp_err`=0.
- Reset mid-BUSY with LATENCY=4: `rst_n` low 2 cycles after acceptance. Then:
  - `rsp_valid` never asserts.
  - `req_ready`=1 after release.
  - A subsequent LW completes normally.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// Request/response bus between the memory stage of the pipeline and the
// data-memory responder. The master side, which is the pipeline or a bench,
// issues requests. The slave side, which is the responder, accepts them and
// returns one response strobe per request.
//
// Signals:
//   req_valid  request present
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data (low bytes used for SB/SH)
//   req_ctrl   DMCtrl / funct3 access encoding
//   req_ready  responder can accept a request this cycle
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  extended load data, zero for stores and outside rsp_valid
//   rsp_err    misaligned-access flag, qualified by rsp_valid
//   stall      hold request back to the pipeline hazard logic
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_ctrl,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_ctrl,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Multi-cycle data memory for the segmented RISC-V core. The block accepts
// one load or store at a time. It performs byte, half or word accesses
// selected by DMCtrl (funct3). A response strobe appears LATENCY clock edges
// after acceptance. While a request is outstanding, stall holds the pipeline.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      edges from acceptance to the response cycle (1..15)
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (array contents are kept)
//   bus          data_mem_responder_if.slave request/response bundle
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   When defined, misaligned half/word accesses raise rsp_err. Such stores
//   are dropped and such loads return zero.
//   When undefined, the misaligned low address bits are forced to zero,
//   the access proceeds, and rsp_err is tied low.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} StateType;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} SizeType;

    StateType    state, nextState;
    logic [3:0]  count, nextCount;

    logic [31:0] memArray [DEPTH_WORDS];
    logic [31:0] readData;

    logic        accept;
    SizeType     reqSize;
    logic [1:0]  effOffset;
    logic [3:0]  byteEn;
    logic [31:0] storeData;
    logic        reqErr;
    logic [AW-1:0] wordIdx;

    SizeType     latchedSize;
    logic [1:0]  latchedOffset;
    logic        latchedSigned;
    logic        latchedWe;
    logic        latchedErr;

    logic [31:0] loadValue;
    logic        unusedAddrBits;

    assign wordIdx        = bus.req_addr[AW+1:2];
    assign unusedAddrBits = ^bus.req_addr[31:AW+2];

    // Decode the incoming request. Codes 000/100 are byte accesses and
    // 001/101 are half accesses. Every other code falls back to a word
    // access. The effective offset drops any misaligned low bits. In the
    // trap build that offset is never used for a misaligned access, because
    // the access is suppressed.
    always_comb begin
        reqSize   = SZ_WORD;
        effOffset = 2'b00;
        byteEn    = 4'b1111;
        storeData = bus.req_wdata;
        if (bus.req_ctrl[1:0] == 2'b00) begin
            reqSize   = SZ_BYTE;
            effOffset = bus.req_addr[1:0];
            byteEn    = 4'b0001 << effOffset;
            storeData = {4{bus.req_wdata[7:0]}};
        end else if (bus.req_ctrl[1:0] == 2'b01) begin
            reqSize   = SZ_HALF;
            effOffset = {bus.req_addr[1], 1'b0};
            byteEn    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            storeData = {2{bus.req_wdata[15:0]}};
        end
    end

    // Misalignment flag for the incoming request. It only exists when the
    // trap feature is built in.
`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        reqErr = 1'b0;
        if (reqSize == SZ_HALF && bus.req_addr[0])
            reqErr = 1'b1;
        else if (reqSize == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            reqErr = 1'b1;
    end
`else
    assign reqErr = 1'b0;
`endif

    // Next-state logic and the handshake outputs. The request is accepted
    // only in IDLE. The counter then counts the remaining BUSY edges down,
    // so the response cycle lands exactly LATENCY edges after acceptance.
    always_comb begin
        nextState     = state;
        nextCount     = count;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.stall     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.stall     = bus.req_valid;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    nextCount = LOAD_COUNT;
                    nextState = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                bus.stall = 1'b1;
                nextCount = count - 4'd1;
                if (count == 4'd1)
                    nextState = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                nextState     = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // State register, plus the request attributes the response path needs
    // after the bus inputs have moved on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= 4'd0;
            latchedSize   <= SZ_WORD;
            latchedOffset <= 2'b00;
            latchedSigned <= 1'b0;
            latchedWe     <= 1'b0;
            latchedErr    <= 1'b0;
        end else begin
            state <= nextState;
            count <= nextCount;
            if (accept) begin
                latchedSize   <= reqSize;
                latchedOffset <= effOffset;
                latchedSigned <= ~bus.req_ctrl[2];
                latchedWe     <= bus.req_we;
                latchedErr    <= reqErr;
            end
        end
    end

    // The storage array is deliberately left unreset. Writes and reads both
    // happen on the acceptance edge. They are gated with rst_n, so a request
    // seen on the same edge as a reset assertion never reaches the array.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            if (bus.req_we) begin
                if (!reqErr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteEn[b])
                            memArray[wordIdx][b*8 +: 8] <= storeData[b*8 +: 8];
                    end
                end
            end else begin
                readData <= memArray[wordIdx];
            end
        end
    end

    // Select and extend the load result from the word captured at
    // acceptance. Stores and trapped accesses return zero.
    always_comb begin
        loadValue = 32'd0;
        if (!latchedWe && !latchedErr) begin
            case (latchedSize)
                SZ_BYTE: begin
                    loadValue[7:0]  = readData[latchedOffset*8 +: 8];
                    loadValue[31:8] = {24{latchedSigned & loadValue[7]}};
                end
                SZ_HALF: begin
                    loadValue[15:0]  = latchedOffset[1] ? readData[31:16] : readData[15:0];
                    loadValue[31:16] = {16{latchedSigned & loadValue[15]}};
                end
                default: loadValue = readData;
            endcase
        end
    end

    assign bus.rsp_rdata = bus.rsp_valid ? loadValue : 32'd0;
    assign bus.rsp_err   = bus.rsp_valid & latchedErr;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Scoreboard bench for data_mem_responder. Requests push their expected
// response, including the expected cycle, into a queue. A monitor pops and
// compares the queue on every rsp_valid. A second instance with LATENCY=4
// covers reset asserted while a request is in flight.
// Expectations for misaligned accesses follow DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_responder;

    localparam int LAT  = 2;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4N;

    always #5 clk = ~clk;

    data_mem_responder_if bus();
    data_mem_responder_if bus4();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT4)) dut4 (
        .clk(clk), .rst_n(rst4N), .bus(bus4)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycle;
        string       name;
    } ExpType;

    ExpType expQ[$];
    ExpType monItem;
    int vecCount  = 0;
    int missCount = 0;
    int cycle     = 0;

    // Count rising edges. The count is stable when sampled on falling edges.
    always @(posedge clk) cycle <= cycle + 1;

    // Compare one value and keep the tallies.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL unexpectedRsp: got rsp_valid 1 with no request pending, expected 0");
            end else begin
                monItem = expQ.pop_front();
                checkOutput({monItem.name, ".rdata"}, bus.rsp_rdata, monItem.data);
                checkOutput({monItem.name, ".err"}, {31'd0, bus.rsp_err}, {31'd0, monItem.err});
                checkOutput({monItem.name, ".cycle"}, 32'(cycle), 32'(monItem.cycle));
                checkOutput({monItem.name, ".stall"}, {31'd0, bus.stall}, 32'd0);
                checkOutput({monItem.name, ".ready"}, {31'd0, bus.req_ready}, 32'd0);
            end
        end
    end

    // Issue one request on the main instance and record its expected
    // response. The acceptance edge is the next rising edge. The response is
    // sampled on the falling edge after edge (acceptance + LAT - 1).
    task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] ctrl,
                                 input logic [31:0] expData, input logic expErr);
        int waitCycles = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (bus.req_ready !== 1'b1) begin
            checkOutput({name, ".readyTimeout"}, {31'd0, bus.req_ready}, 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_ctrl  = ctrl;
        expQ.push_back('{expData, expErr, cycle + LAT, name});
        #1;
        checkOutput({name, ".stallAccept"}, {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = ~wdata;
        bus.req_ctrl  = 3'b111;
        #1;
        checkOutput({name, ".stallBusy"}, {31'd0, bus.stall}, 32'd1);
    endtask

    // Issue one request on the LATENCY=4 instance. Report the returned data
    // and the number of falling edges until rsp_valid, which is -1 on timeout.
    task automatic dut4Request(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] ctrl, output logic [31:0] data, output int lat);
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_we    = we;
        bus4.req_addr  = addr;
        bus4.req_wdata = wdata;
        bus4.req_ctrl  = ctrl;
        lat  = -1;
        data = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus4.req_valid = 1'b0;
            if (bus4.rsp_valid === 1'b1) begin
                lat  = i;
                data = bus4.rsp_rdata;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rdata4;
        int          lat4;
        logic        sawRsp;

        rst_n = 1'b0;
        rst4N = 1'b0;
        bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = 32'd0;
        bus.req_wdata  = 32'd0; bus.req_ctrl = 3'b010;
        bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = 32'd0;
        bus4.req_wdata = 32'd0; bus4.req_ctrl = 3'b010;

        // Reset state, and stall following req_valid during reset.
        repeat (2) @(negedge clk);
        checkOutput("reset.ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("reset.rspValid", {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput("reset.rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset.err", {31'd0, bus.rsp_err}, 32'd0);
        checkOutput("reset.stallLow", {31'd0, bus.stall}, 32'd0);
        bus.req_valid = 1'b1;
        #1;
        checkOutput("reset.stallHigh", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        rst4N = 1'b1;
        #1;
        checkOutput("reset.readyAfter", {31'd0, bus.req_ready}, 32'd1);

        // Word store and load.
        applyStimulus("swDeadbeef", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        applyStimulus("lw10",       1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
        applyStimulus("lb10",       1'b0, 32'h10, 32'h0,        3'b000, 32'hFFFFFFEF, 1'b0);
        applyStimulus("lh12",       1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0);

        // Byte and half loads with sign and zero extension.
        applyStimulus("sw80ff",     1'b1, 32'h20, 32'h80FF7F01, 3'b010, 32'h0, 1'b0);
        applyStimulus("lb23",       1'b0, 32'h23, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
        applyStimulus("lbu23",      1'b0, 32'h23, 32'h0,        3'b100, 32'h00000080, 1'b0);
        applyStimulus("lh22",       1'b0, 32'h22, 32'h0,        3'b001, 32'hFFFF80FF, 1'b0);
        applyStimulus("lhu20",      1'b0, 32'h20, 32'h0,        3'b101, 32'h00007F01, 1'b0);
        applyStimulus("lb21",       1'b0, 32'h21, 32'h0,        3'b000, 32'h0000007F, 1'b0);

        // Partial stores merge into the existing word.
        applyStimulus("sw1122",     1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0);
        applyStimulus("sbAA",       1'b1, 32'h21, 32'hFFFFFFAA, 3'b000, 32'h0, 1'b0);
        applyStimulus("lwAfterSb",  1'b0, 32'h20, 32'h0,        3'b010, 32'h1122AA44, 1'b0);
        applyStimulus("shBeef",     1'b1, 32'h22, 32'hFFFFBEEF, 3'b001, 32'h0, 1'b0);
        applyStimulus("lwAfterSh",  1'b0, 32'h20, 32'h0,        3'b010, 32'hBEEFAA44, 1'b0);
        applyStimulus("lwCtrl111",  1'b0, 32'h20, 32'h0,        3'b111, 32'hBEEFAA44, 1'b0);

        // Address wrap modulo DEPTH_WORDS*4.
        applyStimulus("swWrap",     1'b1, 32'h400, 32'h5, 3'b010, 32'h0, 1'b0);
        applyStimulus("lwWrap",     1'b0, 32'h0,   32'h0, 3'b010, 32'h5, 1'b0);

        // Misaligned accesses.
        applyStimulus("swCafe",     1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus("lw21Mis",    1'b0, 32'h21, 32'h0,        3'b010, 32'h0, 1'b1);
        applyStimulus("sw22Mis",    1'b1, 32'h22, 32'h12345678, 3'b010, 32'h0, 1'b1);
        applyStimulus("lwAfterMis", 1'b0, 32'h20, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0);
        applyStimulus("lhu23Mis",   1'b0, 32'h23, 32'h0,        3'b101, 32'h0, 1'b1);
        applyStimulus("lbAfterMis", 1'b0, 32'h21, 32'h0,        3'b000, 32'hFFFFFFF0, 1'b0);
`else
        applyStimulus("lw21Mis",    1'b0, 32'h21, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0);
        applyStimulus("sw22Mis",    1'b1, 32'h22, 32'h12345678, 3'b010, 32'h0, 1'b0);
        applyStimulus("lwAfterMis", 1'b0, 32'h20, 32'h0,        3'b010, 32'h12345678, 1'b0);
        applyStimulus("lhu23Mis",   1'b0, 32'h23, 32'h0,        3'b101, 32'h00001234, 1'b0);
        applyStimulus("lbAfterMis", 1'b0, 32'h21, 32'h0,        3'b000, 32'h00000056, 1'b0);
`endif

        // Drain the scoreboard.
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        // Reset during BUSY on the LATENCY=4 instance. The store is accepted
        // at E0, and reset is asserted two cycles later for two cycles.
        dut4Request(1'b1, 32'h40, 32'h55, 3'b010, rdata4, lat4);
        checkOutput("lat4.store", 32'(lat4), 32'd4);
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_we    = 1'b1;
        bus4.req_addr  = 32'h44;
        bus4.req_wdata = 32'h66;
        bus4.req_ctrl  = 3'b010;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        sawRsp = 1'b0;
        @(negedge clk);
        rst4N = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus4.rsp_valid !== 1'b0) sawRsp = 1'b1;
        end
        rst4N = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus4.rsp_valid !== 1'b0) sawRsp = 1'b1;
        end
        checkOutput("midBusy.noRsp", {31'd0, sawRsp}, 32'd0);
        checkOutput("midBusy.readyAfter", {31'd0, bus4.req_ready}, 32'd1);

        // A store seen on an edge while reset is low is never committed.
        @(negedge clk);
        rst4N = 1'b0;
        bus4.req_valid = 1'b1;
        bus4.req_we    = 1'b1;
        bus4.req_addr  = 32'h40;
        bus4.req_wdata = 32'h99;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        rst4N = 1'b1;

        dut4Request(1'b0, 32'h40, 32'h0, 3'b010, rdata4, lat4);
        checkOutput("afterReset.lw40", rdata4, 32'h55);
        checkOutput("afterReset.lat", 32'(lat4), 32'd4);
        dut4Request(1'b0, 32'h44, 32'h0, 3'b010, rdata4, lat4);
        checkOutput("afterReset.lw44", rdata4, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
